count_sched: RTL



---
 rtl/count_pkg.sv | 37 +++
 rtl/count_rr_arb.sv | 32 +++
 rtl/count_sched.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/count_pkg.sv
// Shared types and defaults for the count_sched command scheduler.
// Holds the command opcode and scheduler state encodings plus the
// helper that picks the first state after a command is accepted.
package count_pkg;

    localparam int CS_WIDTH = 4;
    localparam int CS_LEN_W = 8;

    // Command opcodes as carried on reqN_op.
    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_UP   = 2'b01,
        OP_DOWN = 2'b10,
        OP_HOLD = 2'b11
    } op_t;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_RUN  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    // First state after a handshake: LOAD always takes its one-cycle slot,
    // a zero-length run has nothing to do and finishes immediately.
    function automatic state_t idle_next(input op_t op, input logic len_zero);
        if (op == OP_LOAD) begin
            return S_LOAD;
        end else if (len_zero) begin
            return S_DONE;
        end else begin
            return S_RUN;
        end
    endfunction

endpackage

// File: rtl/count_rr_arb.sv
// Two-way round-robin arbiter. With a single valid requester that one is
// granted; with both valid the requester not granted last wins. The
// preference pointer only moves when the grant is actually accepted.
module count_rr_arb (
    input  logic clk,
    input  logic reset,
    input  logic valid0,
    input  logic valid1,
    input  logic accept,
    output logic grant_vld,
    output logic grant_id
);

    // 1 means requester 1 wins a tie; after reset requester 0 is favoured.
    logic prefer1;

    // Grant selection from the current valids and the tie-break pointer.
    always_comb begin
        grant_vld = valid0 | valid1;
        grant_id  = valid1 & (~valid0 | prefer1);
    end

    // Pointer flips to the other requester each time a grant is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prefer1 <= 1'b0;
        end else if (accept) begin
            prefer1 <= ~grant_id;
        end
    end

endmodule

// File: rtl/count_sched.sv
// count_sched: sequences an external up/down loadable counter on behalf of
// two requesters. A valid/ready handshake (ready only for the granted
// requester while IDLE; transfer on valid && ready at the clock edge)
// captures one command, which then drives load/din/up_down for its run.
// Whenever no command is steering it, the counter is frozen by reloading
// its own output.
// Optional build macro COUNT_SCHED_SAT_EN: UP/DOWN runs stop at the
// counter limits instead of wrapping, and flag it on sat in DONE.
module count_sched
    import count_pkg::*;
#(
    parameter int WIDTH = CS_WIDTH,
    parameter int LEN_W = CS_LEN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [LEN_W-1:0] req0_len,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [LEN_W-1:0] req1_len,
    input  logic [WIDTH-1:0] cnt_count,
    output logic             cnt_load,
    output logic [WIDTH-1:0] cnt_din,
    output logic             cnt_up_down,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic             sat
);

    state_t           state;
    state_t           state_n;
    op_t              op_q;
    logic [WIDTH-1:0] data_q;
    logic [LEN_W-1:0] len_q;
    logic             id_q;

    logic             grant_vld;
    logic             grant_id;
    logic             accept;
    logic             sat_hit;

    op_t              op_sel;
    logic [WIDTH-1:0] data_sel;
    logic [LEN_W-1:0] len_sel;

    count_rr_arb u_arb (
        .clk       (clk),
        .reset     (reset),
        .valid0    (req0_valid),
        .valid1    (req1_valid),
        .accept    (accept),
        .grant_vld (grant_vld),
        .grant_id  (grant_id)
    );

    // Handshake: only in IDLE, and never while reset is asserted.
    always_comb begin
        accept     = (state == S_IDLE) && grant_vld && !reset;
        req0_ready = accept && !grant_id;
        req1_ready = accept && grant_id;
    end

    // Command fields of the granted requester.
    always_comb begin
        op_sel   = grant_id ? op_t'(req1_op) : op_t'(req0_op);
        data_sel = grant_id ? req1_data : req0_data;
        len_sel  = grant_id ? req1_len  : req0_len;
    end

`ifdef COUNT_SCHED_SAT_EN
    logic sat_q;

    // Limit detection: the step this cycle would wrap the counter.
    always_comb begin
        sat_hit = (state == S_RUN) &&
                  (((op_q == OP_UP) && (&cnt_count)) ||
                   ((op_q == OP_DOWN) && (~|cnt_count)));
    end

    // Remember that the current command stopped at a limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_q <= 1'b0;
        end else if (accept) begin
            sat_q <= 1'b0;
        end else if (sat_hit) begin
            sat_q <= 1'b1;
        end
    end

    // Saturation flag is reported alongside the done pulse.
    always_comb begin
        sat = (state == S_DONE) && sat_q;
    end
`else
    // Without limit handling the counter simply wraps.
    always_comb begin
        sat_hit = 1'b0;
        sat     = 1'b0;
    end
`endif

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n = idle_next(op_sel, len_sel == '0);
                end
            end
            S_LOAD: state_n = S_DONE;
            S_RUN: begin
                if (sat_hit || (len_q == LEN_W'(1))) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // State register, command capture and run-length down-counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            op_q   <= OP_LOAD;
            data_q <= '0;
            len_q  <= '0;
            id_q   <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                op_q   <= op_sel;
                data_q <= data_sel;
                len_q  <= len_sel;
                id_q   <= grant_id;
            end else if (state == S_RUN) begin
                len_q <= sat_hit ? '0 : len_q - LEN_W'(1);
            end
        end
    end

    // Output decode: hold the counter unless a command steers it.
    always_comb begin
        cnt_load    = 1'b1;
        cnt_din     = cnt_count;
        cnt_up_down = 1'b0;
        busy        = (state != S_IDLE);
        done        = 1'b0;
        done_id     = 1'b0;
        case (state)
            S_LOAD: cnt_din = data_q;
            S_RUN: begin
                if (((op_q == OP_UP) || (op_q == OP_DOWN)) && !sat_hit) begin
                    cnt_load    = 1'b0;
                    cnt_up_down = (op_q == OP_UP);
                end
            end
            S_DONE: begin
                done    = 1'b1;
                done_id = id_q;
            end
            default: ;
        endcase
    end

endmodule
